// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the alu_arbiter.
// slave: the arbiter's view. master: the requesters plus the external ALU.
interface alu_arbiter_if #(
    parameter int unsigned W = 32
);
    // Requester 0
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_in1;
    logic [W-1:0] req0_in2;
    logic [3:0]   req0_op;
    // Requester 1
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_in1;
    logic [W-1:0] req1_in2;
    logic [3:0]   req1_op;
    // Responses; data/flags are shared and qualified by the per-port valid
    logic         resp0_valid;
    logic         resp0_ready;
    logic         resp1_valid;
    logic         resp1_ready;
    logic [W-1:0] resp_data;
    logic         resp_cout;
    logic         resp_ovf;
    // ALU datapath
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_out;
    logic         alu_cout;
    logic         alu_ovf;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_op,
        input  req1_valid, req1_in1, req1_in2, req1_op,
        input  resp0_ready, resp1_ready,
        input  alu_out, alu_cout, alu_ovf,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, resp_cout, resp_ovf,
        output alu_in1, alu_in2, alu_ctrl
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_op,
        output req1_valid, req1_in1, req1_in2, req1_op,
        output resp0_ready, resp1_ready,
        output alu_out, alu_cout, alu_ovf,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, resp_cout, resp_ovf,
        input  alu_in1, alu_in2, alu_ctrl
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared ALU. One request at a time is
// latched into the ALU input registers, held for ALU_LAT cycles, and the captured
// result is returned to the winner over a valid/ready handshake.
module alu_arbiter #(
    parameter int unsigned W       = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_check
        $error("alu_arbiter: ALU_LAT must be in 1..15");
    end

    localparam logic [3:0] LatInit = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e       state_q;
    logic         prio_q;
    logic         owner_q;
    logic [3:0]   lat_cnt_q;
    logic [W-1:0] alu_in1_q;
    logic [W-1:0] alu_in2_q;
    logic [3:0]   alu_ctrl_q;
    logic [W-1:0] resp_data_q;
    logic         resp_cout_q;
    logic         resp_ovf_q;
    logic         resp0_valid_q;
    logic         resp1_valid_q;

    logic grant0;
    logic grant1;
    logic resp_hs;

    // Grant decode: only in IDLE; prio breaks ties, a lone requester always wins.
    always_comb begin
        grant0  = (state_q == StIdle) && bus.req0_valid && (!prio_q || !bus.req1_valid);
        grant1  = (state_q == StIdle) && bus.req1_valid && (prio_q || !bus.req0_valid);
        // Only the owner's ready completes the response; the other port is ignored.
        resp_hs = owner_q ? (resp1_valid_q && bus.resp1_ready)
                          : (resp0_valid_q && bus.resp0_ready);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            prio_q        <= 1'b0;
            owner_q       <= 1'b0;
            lat_cnt_q     <= 4'd0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            alu_ctrl_q    <= 4'd0;
            resp_data_q   <= '0;
            resp_cout_q   <= 1'b0;
            resp_ovf_q    <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        owner_q    <= grant1;
                        prio_q     <= ~grant1;
                        alu_in1_q  <= grant1 ? bus.req1_in1 : bus.req0_in1;
                        alu_in2_q  <= grant1 ? bus.req1_in2 : bus.req0_in2;
                        alu_ctrl_q <= grant1 ? bus.req1_op  : bus.req0_op;
                        lat_cnt_q  <= LatInit;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (lat_cnt_q != 4'd0) begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end else begin
                        resp_data_q   <= bus.alu_out;
                        resp_cout_q   <= bus.alu_cout;
                        resp_ovf_q    <= bus.alu_ovf;
                        resp0_valid_q <= ~owner_q;
                        resp1_valid_q <= owner_q;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (resp_hs) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_cout   = resp_cout_q;
    assign bus.resp_ovf    = resp_ovf_q;
    assign bus.alu_in1     = alu_in1_q;
    assign bus.alu_in2     = alu_in2_q;
    assign bus.alu_ctrl    = alu_ctrl_q;

    // Structural invariants: one grant and one response owner at a time.
    assert property (@(posedge clk) !(grant0 && grant1));
    assert property (@(posedge clk) !(resp0_valid_q && resp1_valid_q));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3.
// The bench also plays the external ALU.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.W(32)) if1 ();
    alu_arbiter_if #(.W(32)) if3 ();

    alu_arbiter #(.W(32), .ALU_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n),  .bus(if1));
    alu_arbiter #(.W(32), .ALU_LAT(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3));

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        cout;
        logic        ovf;
        logic [3:0]  op;
        int          acc;
    } exp_t;

    exp_t sb  [2][$];
    exp_t nxt [2][2];
    logic pv  [2];
    int   lat [2] = '{1, 3};
    int   grants[$];
    int   gcyc[$];

    // Reference ALU: returns {cout, ovf, out}
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [32:0] s;
        logic        r;
        logic [33:0] res;
        s = {1'b0, a} + {1'b0, b};
        r = 1'b0;
        case (op)
            4'b0001: r = (a == b);
            4'b1001: r = (a != b);
            4'b0101: r = ($signed(a) <  $signed(b));
            4'b0011: r = ($signed(a) >  $signed(b));
            4'b1101: r = ($signed(a) <= $signed(b));
            4'b1011: r = ($signed(a) >= $signed(b));
            default: r = 1'b0;
        endcase
        if (op == 4'b0000) res = {s[32], (a[31] == b[31]) && (s[31] != a[31]), s[31:0]};
        else               res = {2'b00, 31'd0, r};
        return res;
    endfunction

    always_comb {if1.alu_cout, if1.alu_ovf, if1.alu_out} = alu_f(if1.alu_in1, if1.alu_in2, if1.alu_ctrl);
    always_comb {if3.alu_cout, if3.alu_ovf, if3.alu_out} = alu_f(if3.alu_in1, if3.alu_in2, if3.alu_ctrl);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor step: push on request handshake, check on response handshake.
    task automatic mon(input int d, input logic [1:0] rv, input logic [1:0] rr,
                       input logic [1:0] qv, input logic [1:0] qr, input logic [31:0] data,
                       input logic cout, input logic ovf, input logic [3:0] ctrl);
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            if (rv[p] && rr[p]) begin
                e       = nxt[d][p];
                e.owner = (p == 1);
                e.acc   = cyc;
                sb[d].push_back(e);
                if (d == 0) begin
                    grants.push_back(p);
                    gcyc.push_back(cyc);
                end
            end
        end
        if (qv != 2'b00) begin
            if (sb[d].size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp dut%0d: got valid=%b want 00 (cycle %0d)", d, qv, cyc);
            end else begin
                e = sb[d][0];
                if (!pv[d])
                    chk($sformatf("resp_latency dut%0d", d), 64'(cyc - e.acc), 64'(lat[d] + 1));
                if ((qv & qr) != 2'b00) begin
                    void'(sb[d].pop_front());
                    chk($sformatf("resp_owner dut%0d", d), 64'(qv), e.owner ? 64'd2 : 64'd1);
                    chk($sformatf("resp_data dut%0d", d), 64'(data), 64'(e.data));
                    chk($sformatf("resp_cout dut%0d", d), 64'(cout), 64'(e.cout));
                    chk($sformatf("resp_ovf dut%0d", d), 64'(ovf), 64'(e.ovf));
                    chk($sformatf("alu_ctrl dut%0d", d), 64'(ctrl), 64'(e.op));
                end
            end
        end
        pv[d] = (qv != 2'b00);
    endtask

    always @(negedge clk) begin
        mon(0, {if1.req1_valid, if1.req0_valid}, {if1.req1_ready, if1.req0_ready},
            {if1.resp1_valid, if1.resp0_valid}, {if1.resp1_ready, if1.resp0_ready},
            if1.resp_data, if1.resp_cout, if1.resp_ovf, if1.alu_ctrl);
        mon(1, {if3.req1_valid, if3.req0_valid}, {if3.req1_ready, if3.req0_ready},
            {if3.resp1_valid, if3.resp0_valid}, {if3.resp1_ready, if3.resp0_ready},
            if3.resp_data, if3.resp_cout, if3.resp_ovf, if3.alu_ctrl);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int d);
        sb[d].delete();
        pv[d] = 1'b0;
    endtask

    task automatic chk_reset(input string tag, input logic [1:0] rr, input logic [1:0] qv,
                             input logic [31:0] data, input logic cout, input logic ovf,
                             input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl);
        chk({tag, " req_ready"}, 64'(rr), 64'd0);
        chk({tag, " resp_valid"}, 64'(qv), 64'd0);
        chk({tag, " resp_data"}, 64'(data), 64'd0);
        chk({tag, " resp_cout"}, 64'(cout), 64'd0);
        chk({tag, " resp_ovf"}, 64'(ovf), 64'd0);
        chk({tag, " alu_in1"}, 64'(a), 64'd0);
        chk({tag, " alu_in2"}, 64'(b), 64'd0);
        chk({tag, " alu_ctrl"}, 64'(ctrl), 64'd0);
    endtask

    task automatic chk_reset1(input string tag);
        chk_reset(tag, {if1.req1_ready, if1.req0_ready}, {if1.resp1_valid, if1.resp0_valid},
                  if1.resp_data, if1.resp_cout, if1.resp_ovf, if1.alu_in1, if1.alu_in2,
                  if1.alu_ctrl);
    endtask

    task automatic reset1(input string tag);
        rst_n = 1'b0;
        tick();
        flush(0);
        chk_reset1(tag);
        tick();
        rst_n = 1'b1;
    endtask

    // Present a request on dut1 port p with its hand-computed expected response.
    task automatic set_req1(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] r, input logic c,
                            input logic o);
        nxt[0][p].data = r;
        nxt[0][p].cout = c;
        nxt[0][p].ovf  = o;
        nxt[0][p].op   = op;
        if (p == 0) begin
            if1.req0_in1 = a; if1.req0_in2 = b; if1.req0_op = op; if1.req0_valid = 1'b1;
        end else begin
            if1.req1_in1 = a; if1.req1_in2 = b; if1.req1_op = op; if1.req1_valid = 1'b1;
        end
    endtask

    // Wait for the accept, then drop valid; returns one cycle after the accept edge.
    task automatic wait_acc1(input int p, output int acc);
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p == 0 ? if1.req0_ready : if1.req1_ready) begin
                acc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout port%0d: got no ready want ready within 20 cycles", p);
        end
        tick();
        if (p == 0) if1.req0_valid = 1'b0;
        else        if1.req1_valid = 1'b0;
    endtask

    task automatic send1(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] r, input logic c,
                         input logic o);
        int acc;
        set_req1(p, a, b, op, r, c, o);
        wait_acc1(p, acc);
    endtask

    task automatic wait_idle(input int d);
        int ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (sb[d].size() == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (ok == 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout dut%0d: got %0d pending want 0", d, sb[d].size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops [6] = '{4'b0001, 4'b1001, 4'b0101, 4'b0011, 4'b1101, 4'b1011};
        logic [31:0] exs [6] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
        int acc;
        int n;

        {if1.req0_valid, if1.req1_valid, if3.req0_valid, if3.req1_valid} = '0;
        {if1.req0_in1, if1.req0_in2, if1.req1_in1, if1.req1_in2} = '0;
        {if3.req0_in1, if3.req0_in2, if3.req1_in1, if3.req1_in2} = '0;
        {if1.req0_op, if1.req1_op, if3.req0_op, if3.req1_op} = '0;
        {if1.resp0_ready, if1.resp1_ready, if3.resp0_ready, if3.resp1_ready} = 4'hf;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        tick();
        tick();
        chk_reset1("reset dut1");
        chk_reset("reset dut3", {if3.req1_ready, if3.req0_ready}, {if3.resp1_valid, if3.resp0_valid},
                  if3.resp_data, if3.resp_cout, if3.resp_ovf, if3.alu_in1, if3.alu_in2, if3.alu_ctrl);
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        tick();

        // ADD 1+1 with exact cycle checks around the accept
        set_req1(0, 32'd1, 32'd1, 4'b0000, 32'd2, 1'b0, 1'b0);
        wait_acc1(0, acc);
        @(negedge clk);
        chk("add alu_ctrl c1", 64'(if1.alu_ctrl), 64'd0);
        chk("add alu_in1 c1", 64'(if1.alu_in1), 64'd1);
        chk("add resp0_valid c1", 64'(if1.resp0_valid), 64'd0);
        @(negedge clk);
        chk("add resp0_valid c2", 64'(if1.resp0_valid), 64'd1);
        chk("add resp_data c2", 64'(if1.resp_data), 64'd2);
        chk("add resp1_valid c2", 64'(if1.resp1_valid), 64'd0);
        tick();
        wait_idle(0);

        // Compare sweep on 1,1 via req1
        for (int i = 0; i < 6; i++) begin
            send1(1, 32'd1, 32'd1, ops[i], exs[i], 1'b0, 1'b0);
            wait_idle(0);
        end

        // Contention from reset: expect 0,1,0,1 spaced 3 cycles
        reset1("reset contention");
        grants.delete();
        gcyc.delete();
        set_req1(0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0, 1'b0);
        set_req1(1, 32'd2, 32'd2, 4'b0001, 32'd1, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if1.req0_ready || if1.req1_ready) n++;
            if (n == 4) break;
            @(posedge clk);
            #1;
        end
        tick();
        if1.req0_valid = 1'b0;
        if1.req1_valid = 1'b0;
        wait_idle(0);
        chk("contention grant count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            chk($sformatf("contention grant%0d", i), 64'(grants[i]), 64'(i % 2));
            if (i > 0) chk($sformatf("contention spacing%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end

        // Backpressure on resp0 while req1 waits
        if1.resp0_ready = 1'b0;
        send1(0, 32'd10, 32'd20, 4'b0000, 32'd30, 1'b0, 1'b0);
        set_req1(1, 32'd7, 32'd8, 4'b0000, 32'd15, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp resp0_valid %0d", i), 64'(if1.resp0_valid), 64'd1);
            chk($sformatf("bp resp_data %0d", i), 64'(if1.resp_data), 64'd30);
            chk($sformatf("bp req1_ready %0d", i), 64'(if1.req1_ready), 64'd0);
            tick();
        end
        if1.resp0_ready = 1'b1;
        @(negedge clk);
        chk("bp req1_ready at handshake", 64'(if1.req1_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("bp req1 accepted after handshake", 64'(if1.req1_ready), 64'd1);
        tick();
        if1.req1_valid = 1'b0;
        wait_idle(0);

        // Reset during ISSUE (req1 owner)
        send1(1, 32'd4, 32'd4, 4'b0000, 32'd8, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        flush(0);
        chk_reset1("reset in issue");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("no stale resp issue %0d", i),
                64'({if1.resp1_valid, if1.resp0_valid}), 64'd0);
            tick();
        end

        // Reset during RESP (req0 owner, so prio was 1 before reset)
        if1.resp0_ready = 1'b0;
        send1(0, 32'd6, 32'd6, 4'b0000, 32'd12, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("resp pending before reset", 64'(if1.resp0_valid), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        flush(0);
        chk_reset1("reset in resp");
        if1.resp0_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("no stale resp resp %0d", i),
                64'({if1.resp1_valid, if1.resp0_valid}), 64'd0);
            tick();
        end
        set_req1(0, 32'd3, 32'd4, 4'b0000, 32'd7, 1'b0, 1'b0);
        set_req1(1, 32'd9, 32'd9, 4'b1001, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post reset req0 wins", 64'({if1.req1_ready, if1.req0_ready}), 64'd1);
        tick();
        if1.req0_valid = 1'b0;
        wait_acc1(1, acc);
        wait_idle(0);

        // ALU_LAT=3: overflow add, response 4 cycles after accept
        nxt[1][0].data = 32'h8000_0000;
        nxt[1][0].cout = 1'b0;
        nxt[1][0].ovf  = 1'b1;
        nxt[1][0].op   = 4'b0000;
        if3.req0_in1   = 32'h7FFF_FFFF;
        if3.req0_in2   = 32'd1;
        if3.req0_op    = 4'b0000;
        if3.req0_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if3.req0_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        chk("lat3 accepted", 64'(acc >= 0), 64'd1);
        tick();
        if3.req0_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if3.resp0_valid) break;
            tick();
        end
        chk("lat3 accept to resp", 64'(cyc - acc), 64'd4);
        chk("lat3 resp_data", 64'(if3.resp_data), 64'h8000_0000);
        chk("lat3 resp_ovf", 64'(if3.resp_ovf), 64'd1);
        tick();
        wait_idle(1);

        chk("dut1 scoreboard drained", 64'(sb[0].size()), 64'd0);
        chk("dut3 scoreboard drained", 64'(sb[1].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
